// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single byte-wide RAM port between instruction fetch (IF) and the
// MEM stage. Every access is serialised into consecutive byte cycles. Read
// bytes are assembled little-endian; loads are sign- or zero-extended.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   rdy             run enable; 0 freezes every flop
//   if_req/if_addr  fetch request (always 4 bytes)   -> if_done, if_data
//   mem_req/mem_we/mem_funct3/mem_addr/mem_wdata
//                   load/store request                -> mem_done, mem_rdata
//   ram_a/ram_wr/ram_dout  registered RAM address, write strobe, write byte
//   ram_din         RAM read byte, valid the cycle after ram_a is presented
//   busy            arbiter is not idle
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;          // bytes already handled
    logic [2:0]  last_q, last_d;        // byte count N of the access
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;        // read bytes gathered so far
    logic        own_mem_q, own_mem_d;
    logic        zext_q, zext_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic        ram_wr_q, ram_wr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [2:0]  cnt_nx;
    logic [31:0] asm_w;                 // buffer with the current ram_din merged in
    logic [31:0] ld_ext;
    logic        sx;

    function automatic logic [2:0] width_n(input logic [1:0] w);
        case (w)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        own_mem_d   = own_mem_q;
        zext_d      = zext_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        if_done_d   = if_done_q;
        if_data_d   = if_data_q;
        mem_done_d  = mem_done_q;
        mem_rdata_d = mem_rdata_q;

        cnt_nx = cnt_q + 3'd1;
        asm_w  = rbuf_q;
        asm_w[{cnt_q[1:0], 3'b000} +: 8] = ram_din;
        sx = ~zext_q;
        case (last_q)
            3'd1:    ld_ext = {{24{sx & asm_w[7]}},  asm_w[7:0]};
            3'd2:    ld_ext = {{16{sx & asm_w[15]}}, asm_w[15:0]};
            default: ld_ext = asm_w;
        endcase

        // With rdy low everything, including a pending done pulse, is held.
        if (rdy) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = 3'd0;
                    if (mem_req) begin
                        own_mem_d = 1'b1;
                        base_d    = mem_addr;
                        ram_a_d   = mem_addr;
                        last_d    = width_n(mem_funct3[1:0]);
                        zext_d    = mem_funct3[2];
                        wdata_d   = mem_wdata;
                        if (mem_we) begin
                            state_d    = WRITE;
                            ram_wr_d   = 1'b1;
                            ram_dout_d = mem_wdata[7:0];
                        end else begin
                            state_d  = READ;
                            ram_wr_d = 1'b0;
                        end
                    end else if (if_req) begin
                        own_mem_d = 1'b0;
                        base_d    = if_addr;
                        ram_a_d   = if_addr;
                        last_d    = 3'd4;
                        zext_d    = 1'b0;
                        state_d   = READ;
                        ram_wr_d  = 1'b0;
                    end
                end
                READ: begin
                    rbuf_d = asm_w;
                    cnt_d  = cnt_nx;
                    if (cnt_nx == last_q) begin
                        state_d = DONE;
                        if (own_mem_q) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = ld_ext;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = asm_w;
                        end
                    end else begin
                        ram_a_d = base_q + {29'd0, cnt_nx};
                    end
                end
                WRITE: begin
                    cnt_d = cnt_nx;
                    if (cnt_nx == last_q) begin
                        state_d    = DONE;
                        ram_wr_d   = 1'b0;
                        mem_done_d = 1'b1;
                    end else begin
                        ram_a_d    = base_q + {29'd0, cnt_nx};
                        ram_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                    end
                end
                default: state_d = IDLE;  // DONE: requests ignored
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            last_q      <= 3'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            own_mem_q   <= 1'b0;
            zext_q      <= 1'b0;
            ram_a_q     <= 32'd0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_done_q   <= 1'b0;
            if_data_q   <= 32'd0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            own_mem_q   <= own_mem_d;
            zext_q      <= zext_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps from the feature list followed by a
// run of random fetches/loads/stores with random rdy stalls. A byte RAM and a
// separate golden copy of its contents are kept here; expected results come
// from the golden copy with plain arithmetic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy, if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic        if_done, mem_done, ram_wr, busy;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic [7:0]  ram_dout, ram_din;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:1023];
    logic [7:0] gm  [0:1023];
    assign ram_din = ram[ram_a[9:0]];

    // RAM write port values as seen just before the coming rising edge
    logic       wr_l;
    logic [9:0] a_l;
    logic [7:0] d_l;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_if = 0, exp_mem = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic latch_wr();
        wr_l = ram_wr; a_l = ram_a[9:0]; d_l = ram_dout;
    endtask

    // Advance to the next falling edge, applying the RAM write of the edge passed.
    task automatic tick();
        @(negedge clk);
        if (wr_l) ram[a_l] = d_l;
        latch_wr();
    endtask

    task automatic set_byte(input int a, input logic [7:0] d);
        ram[a] = d; gm[a] = d;
    endtask

    function automatic logic [31:0] gm_word(input logic [31:0] a, input int n);
        logic [31:0] w = 0;
        for (int j = 0; j < n; j++) begin
            logic [31:0] aj = a + 32'(j);
            w[8*j +: 8] = gm[aj[9:0]];
        end
        return w;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
        logic [31:0] w = 0;
        for (int j = 0; j < n; j++) begin
            logic [31:0] aj = a + 32'(j);
            w[8*j +: 8] = ram[aj[9:0]];
        end
        return w;
    endfunction

    // One full access. Called at a falling edge with the bus idle; the next
    // rising edge is the grant. rdy is dropped for st_len edges starting with
    // the edge after falling edge number st_at.
    task automatic run(input bit is_mem, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int st_at, input int st_len, input string tag);
        int n, k, rec;
        bit prev_rdy, dn;
        logic [31:0] expv;
        n = !is_mem ? 4 : (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        expv = gm_word(a, n);
        if (is_mem && !we && !f3[2] && n < 4 && expv[8*n-1])
            expv = expv | (32'hFFFF_FFFF << (8*n));
        if (is_mem) begin
            mem_req = 1; mem_we = we; mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
        end else begin
            if_req = 1; if_addr = a;
        end
        k = 0; rec = 0; prev_rdy = 1; dn = 0;
        tick();
        chk({tag, " busy_after_grant"}, busy, 1);
        while (k <= 40) begin
            dn = is_mem ? mem_done : if_done;
            if (dn) break;
            if (prev_rdy) begin
                chk({tag, " ram_a"}, ram_a, a + 32'(rec));
                chk({tag, " ram_wr"}, ram_wr, we);
                if (we && rec < 4) chk({tag, " ram_dout"}, ram_dout, wd[8*rec +: 8]);
                rec++;
            end
            rdy = (k >= st_at && k < st_at + st_len) ? 1'b0 : 1'b1;
            prev_rdy = rdy;
            tick();
            k++;
        end
        rdy = 1;
        chk({tag, " done_seen"}, dn, 1);
        chk({tag, " latency"}, k, n + st_len);
        chk({tag, " bytes_stepped"}, rec, n);
        chk({tag, " ram_wr_at_done"}, ram_wr, 0);
        chk({tag, " other_done"}, is_mem ? if_done : mem_done, 0);
        if (!is_mem) exp_if = expv;
        else if (!we) exp_mem = expv;
        chk({tag, " if_data"}, if_data, exp_if);
        chk({tag, " mem_rdata"}, mem_rdata, exp_mem);
        if (is_mem && we)
            for (int j = 0; j < n; j++) begin
                logic [31:0] aj = a + 32'(j);
                gm[aj[9:0]] = wd[8*j +: 8];
            end
        if (is_mem) mem_req = 0; else if_req = 0;
        tick();
        chk({tag, " done_pulse_end"}, is_mem ? mem_done : if_done, 0);
        chk({tag, " idle_after"}, busy, 0);
        if (is_mem && we) chk({tag, " ram_contents"}, ram_word(a, n), gm_word(a, n));
    endtask

    initial begin
        rdy = 1; if_req = 0; mem_req = 0; mem_we = 0; mem_funct3 = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        wr_l = 0; a_l = 0; d_l = 0;
        for (int i = 0; i < 1024; i++) set_byte(i, 8'($urandom));
        set_byte(32'h100, 8'h78); set_byte(32'h101, 8'h56);
        set_byte(32'h102, 8'h34); set_byte(32'h103, 8'h12);
        set_byte(32'h10, 8'h80);
        set_byte(32'h20, 8'h01); set_byte(32'h21, 8'h80);

        // reset state
        tick(); tick();
        chk("reset ram_a", ram_a, 0);
        chk("reset busy", busy, 0);
        chk("reset ctl", {ram_wr, ram_dout, if_done, mem_done}, 0);
        chk("reset data", if_data | mem_rdata, 0);
        rst = 1;
        tick();

        // word load, byte/half extension
        run(1, 0, 3'b010, 32'h100, 0, 0, 0, "lw100");
        chk("lw100 const", mem_rdata, 32'h1234_5678);
        run(1, 0, 3'b000, 32'h10, 0, 0, 0, "lb");
        chk("lb const", mem_rdata, 32'hFFFF_FF80);
        run(1, 0, 3'b100, 32'h10, 0, 0, 0, "lbu");
        chk("lbu const", mem_rdata, 32'h0000_0080);
        run(1, 0, 3'b001, 32'h20, 0, 0, 0, "lh");
        chk("lh const", mem_rdata, 32'hFFFF_8001);
        run(1, 0, 3'b101, 32'h20, 0, 0, 0, "lhu");
        chk("lhu const", mem_rdata, 32'h0000_8001);

        // half store
        run(1, 1, 3'b001, 32'h202, 32'hAABB_CCDD, 0, 0, "sh202");
        chk("sh202 bytes", ram_word(32'h202, 2), 32'h0000_CCDD);

        // both requests at once: MEM first, IF two edges after mem_done's edge
        if_req = 1; if_addr = 32'h0;
        run(1, 0, 3'b010, 32'h100, 0, 0, 0, "prio_mem");
        chk("prio if_still_waiting", if_done, 0);
        run(0, 0, 3'b000, 32'h0, 0, 0, 0, "prio_if");

        // wrapping fetch with a three-cycle stall after E1
        run(0, 0, 3'b000, 32'hFFFF_FFFE, 0, 1, 3, "fetch_wrap");

        // reset in the middle of a word store
        mem_req = 1; mem_we = 1; mem_funct3 = 3'b010; mem_addr = 32'h300;
        mem_wdata = 32'h1122_3344;
        tick(); tick(); tick();
        rst = 0;
        #1;
        latch_wr();
        chk("rst_mid ram_a", ram_a, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid ctl", {ram_wr, ram_dout, if_done, mem_done}, 0);
        chk("rst_mid data", if_data | mem_rdata, 0);
        exp_if = 0; exp_mem = 0;
        gm[10'h300] = 8'h44; gm[10'h301] = 8'h33;
        mem_req = 0; mem_we = 0;
        tick(); tick();
        rst = 1;
        tick();
        chk("rst_mid ram_contents", ram_word(32'h300, 4), gm_word(32'h300, 4));
        run(1, 0, 3'b010, 32'h300, 0, 0, 0, "lw_after_rst");

        // random traffic
        for (int t = 0; t < 40; t++) begin
            int kind, n, sa, sl;
            logic [2:0] f3;
            logic [31:0] a, wd;
            kind = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            wd = $urandom;
            n = (kind == 0) ? 4 : (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            sa = $urandom_range(0, n - 1);
            sl = $urandom_range(0, 2);
            case (kind)
                0:       run(0, 0, 3'b000, a, 0, sa, sl, "rnd_fetch");
                1:       run(1, 0, f3, a, 0, sa, sl, "rnd_load");
                default: run(1, 1, f3, a, wd, sa, sl, "rnd_store");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and byte-serialiser for the core's single byte-wide RAM port. It shares the port between instruction fetch (IF, always 32-bit reads) and the MEM stage (loads/stores of byte/half/word, with width selected by funct3 from the execute-stage result). Each access is sequenced as consecutive byte cycles. Read bytes are assembled little-endian and sign- or zero-extended for loads.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global run enable; 0 freezes all state
- if_req  in  1  fetch request; held stable until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word
- mem_req  in  1  load/store request; held stable until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_funct3  in  3  [1:0] width: 00 byte, 01 half, 10/11 word; [2] = 1 zero-extend (loads only)
- mem_addr  in  32  byte address (execute-stage mem address)
- mem_wdata  in  32  store data; low N bytes used
- mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
- mem_rdata  out  32  extended load result
- ram_a  out  32  RAM byte address (registered)
- ram_wr  out  1  RAM write strobe (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte; valid the cycle after its address is presented
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ, WRITE, DONE.
- Byte count N: IF = 4; MEM = 1, 2 or 4 from funct3[1:0].
- Counter cnt is 3 bits. Latched base address: A. Address for byte j = A + j, mod 2^32 (wraps).
- IDLE, on an edge:
  - If mem_req, grant MEM (fixed priority over IF).
  - Else if if_req, grant IF.
  - Else stay in IDLE.
  - On grant: latch address, width, we, wdata and the owner; set cnt = 0; set ram_a = A.
  - MEM store: go to WRITE with ram_wr = 1 and ram_dout = wdata[7:0].
  - Otherwise: go to READ with ram_wr = 0.
- READ, edge j (j = 1..N):
  - Capture ram_din into byte j-1.
  - If j < N, set ram_a = A + j.
  - At j = N: go to DONE. Raise the owner's done. Load the owner's data output.
  - IF data: bytes little-endian.
  - Load data: N=1 extends bit 7; N=2 extends bit 15; fill with 0 if funct3[2] = 1.
- WRITE, edge j (j = 1..N-1): set ram_a = A + j and ram_dout = wdata byte j, with ram_wr = 1.
- WRITE, edge N: set ram_wr = 0 and go to DONE with mem_done = 1. mem_rdata is unchanged by stores.
- DONE: the owner's done is high for exactly this cycle. The next edge goes to IDLE. Requests are ignored in DONE.
- The requester must deassert req while its done is high.
- if_data and mem_rdata hold their last value until the next completion for that requester.
- ram_a holds its last value when idle.
- rdy = 0 at an edge: no state, counter, capture or output changes.
  - ram_wr stays at its held value; the same byte is rewritten, which is idempotent.
  - ram_a is unchanged, so ram_din stays consistent on resume.
- rst = 0: asynchronously force state IDLE and cnt 0. All outputs go to 0: ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata, busy.
  - An interrupted store leaves its already-written bytes in RAM; there is no rollback.

## Timing
- Grant at edge E0. For reads, ram_din for byte j is sampled at E(j+1).
- done is high between E_N and E_(N+1).
- The earliest next grant is E_(N+2), so an access occupies N+2 cycles.
- Back-to-back requests: the second requester is granted 2 edges after the first's done edge.
- Each rdy = 0 cycle adds exactly one cycle of latency.
- Request changes in READ, WRITE or DONE have no effect. Request inputs are sampled only in IDLE.

## Test plan
- LW at 0x100, RAM = 78 56 34 12:
  - ram_a must step 0x100, 0x101, 0x102, 0x103 on E0..E3.
  - mem_done must be high for one cycle after E4, with mem_rdata = 0x12345678.
- Sign extension:
  - RAM[0x10] = 0x80: LB → 0xFFFFFF80; LBU → 0x00000080.
  - RAM[0x20..0x21] = 01 80: LH → 0xFFFF8001; LHU → 0x00008001.
- SH wdata 0xAABBCCDD at 0x202:
  - ram_wr must be high 2 cycles, with (ram_a, ram_dout) = (0x202, DD) then (0x203, CC).
  - ram_wr must then be 0, with mem_done one cycle.
- if_req and mem_req both asserted in IDLE (LW 0x100, fetch 0x0):
  - MEM must be served first.
  - IF must be granted 2 edges after mem_done's edge, then if_data = word at 0x0.
- Fetch at 0xFFFFFFFE with rdy = 0 for 3 cycles after E1:
  - ram_a must step FFFFFFFE, FFFFFFFF, 00000000, 00000001.
  - The result must be correct, with if_done 3 cycles later than without stalls.
- SW 0x11223344 at 0x300, rst asserted after E2:
  - All outputs must be 0 immediately and busy = 0.
  - RAM[0x300..0x301] = 44 33; RAM[0x302..0x303] untouched.
  - After release, a new LW must complete normally.
